// File: rtl/mac_stream_feeder.sv
// Frame-buffered AXI4-Stream source feeding packed {weight, data} lanes to the MAC array.
// Beats are preloaded into a local buffer, then streamed as one frame per accepted start.
module mac_stream_feeder #(
  parameter int unsigned NUM_MACS = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [16*NUM_MACS-1:0]  wr_data,
  input  logic                    start,
  input  logic [ADDR_W:0]         frame_len,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err,
  output logic [15:0]             frames_sent,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [16*NUM_MACS-1:0]  m_axis_tdata,
  output logic                    m_axis_tlast
);

  localparam int unsigned BEAT_W = 16 * NUM_MACS;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                busy_d, done_d, len_err_d, tvalid_d, tlast_d, is_last;
  logic [15:0]         frames_sent_d;
  logic [BEAT_W-1:0]   tdata_d;
  logic [BEAT_W-1:0]   mem [DEPTH];

  // Buffer is frozen while a frame is in flight; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  assign idx_nxt = idx_q + ADDR_W'(1);
  assign is_last = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  // Next-state and next-output logic; tvalid never looks at tready combinationally.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    busy_d        = busy;
    done_d        = 1'b0;
    len_err_d     = 1'b0;
    frames_sent_d = frames_sent;
    tvalid_d      = m_axis_tvalid;
    tdata_d       = m_axis_tdata;
    tlast_d       = m_axis_tlast;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((frame_len != '0) && (frame_len <= LEN_W'(DEPTH))) begin
            len_d    = frame_len;
            idx_d    = '0;
            tdata_d  = mem[0];
            tvalid_d = 1'b1;
            tlast_d  = (frame_len == LEN_W'(1));
            busy_d   = 1'b1;
            state_d  = STREAM;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (m_axis_tready) begin
          if (is_last) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            frames_sent_d = frames_sent + 16'd1;
            state_d       = IDLE;
          end else begin
            idx_d   = idx_nxt;
            tdata_d = mem[idx_nxt];
            tlast_d = (LEN_W'(idx_nxt) == (len_q - LEN_W'(1)));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      len_err       <= 1'b0;
      frames_sent   <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      busy          <= busy_d;
      done          <= done_d;
      len_err       <= len_err_d;
      frames_sent   <= frames_sent_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
    end
  end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Directed bench for mac_stream_feeder: frame streaming, stalls, length errors,
// frozen buffer, mid-frame reset and frame counter wrap.
module tb_mac_stream_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;
  logic         start;
  logic [4:0]   frame_len;
  logic         busy, done, len_err;
  logic [15:0]  frames_sent;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [127:0] m_axis_tdata;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_mem [16];
  logic [15:0]  exp_frames;
  logic [127:0] base;
  logic [5:0]   stall_pat;

  mac_stream_feeder dut (
    .clk(clk), .reset(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .len_err(len_err), .frames_sent(frames_sent),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one frame from a negedge. mode 1 toggles tready 1,0,0,1,0,1,...
  // inject: mid-frame write to addr 5 plus a second start; start_wr: write addr 0 in the start cycle.
  task automatic run_frame(input int len, input int mode, input bit inject, input bit start_wr);
    int beats = 0;
    int cyc = 0;
    logic rdy;
    logic [127:0] new0 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    start = 1'b1;
    frame_len = 5'(len);
    if (start_wr) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = new0;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    while (beats < len && cyc < 200) begin
      chk("tvalid_hi", m_axis_tvalid, 1'b1);
      chk("tdata", m_axis_tdata, exp_mem[beats]);
      chk("tlast", m_axis_tlast, (beats == len - 1));
      chk("busy_hi", busy, 1'b1);
      chk("done_lo", done, 1'b0);
      rdy = (mode == 1) ? stall_pat[cyc % 6] : 1'b1;
      if (inject && cyc == 3) begin
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = '1;
        start = 1'b1; frame_len = 5'd4;
      end
      m_axis_tready = rdy;
      if (m_axis_tvalid && rdy) beats++;
      cyc++;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      if (inject && cyc == 4) chk("busy_start_no_len_err", len_err, 1'b0);
    end
    exp_frames = exp_frames + 16'd1;
    chk("beat_count", 128'(beats), 128'(len));
    chk("tvalid_lo_end", m_axis_tvalid, 1'b0);
    chk("tlast_lo_end", m_axis_tlast, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("busy_lo_end", busy, 1'b0);
    chk("tdata_hold", m_axis_tdata, exp_mem[len-1]);
    chk("frames_sent", frames_sent, exp_frames);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    if (start_wr) exp_mem[0] = new0;
  endtask

  initial begin
    logic [4:0] bad_len [2];
    stall_pat = 6'b101001;
    bad_len[0] = 5'd0;
    bad_len[1] = 5'd17;
    base = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    exp_frames = 16'd0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; frame_len = '0; m_axis_tready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_frames", frames_sent, 16'd0);
    rst_n = 1'b1;

    // Preload all 16 entries with base + k.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = base + 128'(k);
      exp_mem[k] = base + 128'(k);
    end
    @(negedge clk);
    wr_en = 1'b0;

    run_frame(4, 0, 1'b0, 1'b0);
    run_frame(4, 1, 1'b0, 1'b0);
    run_frame(1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      start = 1'b1; frame_len = bad_len[i];
      @(negedge clk);
      start = 1'b0;
      chk("len_err_pulse", len_err, 1'b1);
      chk("len_err_busy", busy, 1'b0);
      chk("len_err_tvalid", m_axis_tvalid, 1'b0);
      @(negedge clk);
      chk("len_err_one_cycle", len_err, 1'b0);
      chk("len_err_tvalid2", m_axis_tvalid, 1'b0);
    end

    run_frame(16, 0, 1'b1, 1'b0);
    run_frame(16, 1, 1'b0, 1'b0);
    run_frame(3, 0, 1'b0, 1'b1);
    run_frame(2, 0, 1'b0, 1'b0);

    // Reset while beat 2 of a 4-beat frame is on the bus.
    start = 1'b1; frame_len = 5'd4; m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid_beat0", m_axis_tdata, exp_mem[0]);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_beat2", m_axis_tdata, exp_mem[2]);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", m_axis_tvalid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_frames", frames_sent, 16'd0);
    chk("rstmid_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 16'd0;
    @(negedge clk);
    run_frame(4, 0, 1'b0, 1'b0);

    // Counter wrap from 0xFFFF.
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    exp_frames = 16'hFFFF;
    chk("preset_frames", frames_sent, 16'hFFFF);
    run_frame(1, 0, 1'b0, 1'b0);
    chk("wrap_zero", frames_sent, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_stream_feeder.md
Name: mac_stream_feeder

Overview:
- AXI4-Stream transmitter that sources the packed {weight[7:0], data[7:0]} lane stream consumed by the MAC array.
- Host or controller preloads up to DEPTH 128-bit beats into an internal frame buffer, then pulses start.
- Block streams frame_len beats with full AXI4-Stream valid/ready compliance and tlast on the final beat.
- Sits between the coprocessor's control/load path and the MAC array's s_axis input.

Parameters:
NUM_MACS, 8, lanes per beat; beat width = 16*NUM_MACS (128 at default)
DEPTH, 16, frame buffer entries (beats)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  buffer write address
wr_data  input  16*NUM_MACS  beat to store; lane i = bits [16i+15:16i] = {weight, data}
start  input  1  single-cycle frame start request
frame_len  input  ADDR_W+1  beats in frame, legal 1..DEPTH, sampled on accepted start
busy  output  1  frame in progress
done  output  1  one-cycle pulse after final beat handshake
len_err  output  1  one-cycle pulse when start rejected for illegal frame_len
frames_sent  output  16  completed-frame counter, wraps 0xFFFF->0
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready from MAC array
m_axis_tdata  output  16*NUM_MACS  stream data
m_axis_tlast  output  1  high with tvalid on final beat of frame

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, len_err, m_axis_tvalid, m_axis_tlast = 0; m_axis_tdata = 0; frames_sent = 0; beat index = 0. Buffer contents not reset (undefined after power-up, retained across reset).
- Buffer writes: on clk with wr_en=1 and busy=0, mem[wr_addr] <= wr_data. wr_en while busy=1 is dropped; buffer is frozen during a frame.
- States: IDLE, STREAM.
- IDLE: start=1 with 1<=frame_len<=DEPTH -> latch len, idx<=0, m_axis_tdata<=mem[0], m_axis_tvalid<=1, m_axis_tlast<=(len==1), busy<=1, go STREAM. Latency start->tvalid = 1 cycle.
- IDLE: start=1 with frame_len==0 or >DEPTH -> len_err=1 for one cycle, stay IDLE.
- Same-cycle start and wr_en in IDLE: write completes; the frame reads the pre-write value of that address when it is mem[0] (tdata registered from old contents), later beats see new value.
- STREAM, tvalid=1 and tready=0: tdata, tlast, tvalid held stable (no change until handshake).
- STREAM, handshake and idx!=len-1: idx<=idx+1; tdata<=mem[idx+1]; tvalid stays 1; tlast<=(idx+1==len-1). Sustains one beat per cycle with tready held high.
- STREAM, handshake and idx==len-1: tvalid<=0, tlast<=0, busy<=0, done<=1 (one cycle), frames_sent<=frames_sent+1, go IDLE. tdata retains last value.
- start while busy=1: ignored, no len_err.
- Earliest restart: start in the cycle done=1 is accepted (state is IDLE); gap between frames min 1 idle cycle of tvalid=0.
- Reset asserted mid-frame: tvalid drops immediately, frame abandoned, no done, frames_sent cleared.
- tvalid never depends combinationally on tready.

Test Plan:
- Preload mem[0..3]=128'h0001_0002_..._0008 + k; start, frame_len=4, tready=1 -> tvalid one cycle after start, 4 consecutive beats in order, tlast only on beat 3, done pulse one cycle after beat 3, frames_sent=1.
- Same frame with tready toggling 1,0,0,1,0,1,... -> tdata/tlast stable across every stall, exactly 4 handshakes, beat order intact, no extra beats.
- frame_len=1 -> single beat with tlast=1 on first cycle of tvalid; frame_len=0 and frame_len=17 -> len_err pulse, busy stays 0, tvalid stays 0.
- During a 16-beat frame drive wr_en to addr 5 with 128'hFFFF...; pulse start mid-frame -> beat 5 carries original data, second start ignored, exactly 16 beats, buffer unchanged afterward.
- Assert reset at beat 2 of a 4-beat frame -> tvalid, busy 0 asynchronously; after release, restart frame_len=4 -> full 4 beats from mem[0], preload data retained, frames_sent=1.
- Preset frames_sent to 0xFFFF via 65535 single-beat frames (or force) -> next completed frame wraps frames_sent to 0x0000.
